// File: rtl/fifo_sync_fwft_pkg.sv
// Shared types and sizing helpers for the first-word-fall-through sync FIFO family.
// Capacity counts the RAM plus the two-word output stage.
package fifo_sync_fwft_pkg;

    typedef logic [1:0] os_cnt_t;

    localparam os_cnt_t OS_DEPTH = 2'd2;

    function automatic int fifo_cap(input int aw);
        return (1 << aw) + 2;
    endfunction

    function automatic int fifo_lw(input int aw);
        return aw + 2;
    endfunction

endpackage

// File: rtl/fifo_sync_fwft_if.sv
// Handshake, data, threshold and status bundle of the FWFT FIFO.
// The producer/consumer side uses master; the FIFO itself uses slave.
interface fifo_sync_fwft_if
    import fifo_sync_fwft_pkg::*;
#(
    parameter int DATAWIDTH = 18,
    parameter int LW        = fifo_lw(5)
);
    logic                 flush;
    logic                 clear_err;
    logic [DATAWIDTH-1:0] wr_data;
    logic                 we;
    logic                 ns_full;
    logic                 full;
    logic [LW-1:0]        af_level;
    logic                 almost_full;
    logic                 ovf;
    logic [DATAWIDTH-1:0] ns_rd_data;
    logic [DATAWIDTH-1:0] rd_data;
    logic                 re;
    logic                 ns_ne;
    logic                 ne;
    logic [LW-1:0]        ae_level;
    logic                 almost_empty;
    logic [LW-1:0]        level;
    logic                 unf;

    modport master (
        output flush, clear_err, wr_data, we, af_level, re, ae_level,
        input  ns_full, full, almost_full, ovf, ns_rd_data, rd_data,
               ns_ne, ne, almost_empty, level, unf
    );

    modport slave (
        input  flush, clear_err, wr_data, we, af_level, re, ae_level,
        output ns_full, full, almost_full, ovf, ns_rd_data, rd_data,
               ns_ne, ne, almost_empty, level, unf
    );

endinterface

// File: rtl/fifo_sync_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// No reset on storage or read register so it maps onto block RAM.
module fifo_sync_ram #(
    parameter int DW = 18,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_r [DEPTH];
    logic [DW-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_r[waddr_i] <= wdata_i;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_r[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_sync_fwft.sv
// Single-clock FWFT FIFO: registered-read RAM prefetched into a 2-word output stage,
// with fill level, runtime thresholds, flush and sticky overflow/underflow flags.
module fifo_sync_fwft
    import fifo_sync_fwft_pkg::*;
#(
    parameter int DATAWIDTH = 18,
    parameter int ADDRWIDTH = 5,
    parameter int SLOP      = 4,
    parameter int LW        = fifo_lw(ADDRWIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    fifo_sync_fwft_if.slave  bus
);
    localparam int            CAP    = fifo_cap(ADDRWIDTH);
    localparam logic [LW-1:0] CAP_L  = LW'(CAP);
    localparam logic [LW-1:0] FULL_L = LW'(CAP - SLOP);

    logic [ADDRWIDTH-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDRWIDTH:0]            ram_cnt_q, ram_cnt_d;
    logic                          inflight_q, inflight_d;
    logic [1:0][DATAWIDTH-1:0]     os_mem_q, os_mem_d;
    logic                          os_rd_q, os_rd_d, os_wr_q, os_wr_d;
    os_cnt_t                       os_cnt_q, os_cnt_d;
    logic [LW-1:0]                 level_q, level_d;
    logic [DATAWIDTH-1:0]          rd_data_q;
    logic                          ne_q, full_q, af_q, ae_q, ovf_q, ovf_d, unf_q, unf_d;

    logic                          wr_acc_s, rd_acc_s, ovf_ev_s, unf_ev_s, pre_s;
    logic [2:0]                    os_used_s;
    os_cnt_t                       remain_s;
    logic                          rd_n_s;
    logic [DATAWIDTH-1:0]          ram_dout_s, ns_rd_data_s;
    logic                          ns_ne_s, ns_full_s;

    fifo_sync_ram #(.DW(DATAWIDTH), .AW(ADDRWIDTH)) u_ram (
        .clk     (clk),
        .we_i    (wr_acc_s),
        .waddr_i (wr_ptr_q),
        .wdata_i (bus.wr_data),
        .re_i    (pre_s),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_dout_s)
    );

    // Request qualification, prefetch decision and next state of every register.
    always_comb begin
        wr_acc_s  = bus.we && !bus.flush && (level_q < CAP_L);
        rd_acc_s  = bus.re && ne_q && !bus.flush;
        ovf_ev_s  = bus.we && !bus.flush && (level_q == CAP_L);
        unf_ev_s  = bus.re && !ne_q && !bus.flush;
        // The pop is counted so a slot drained this cycle is refilled at once.
        os_used_s = {1'b0, os_cnt_q} + {2'b00, inflight_q} - {2'b00, rd_acc_s};
        pre_s     = !bus.flush && (ram_cnt_q != '0) && (os_used_s < {1'b0, OS_DEPTH});
        remain_s  = os_cnt_q - os_cnt_t'(rd_acc_s);
        rd_n_s    = os_rd_q ^ rd_acc_s;
        ovf_d     = (ovf_q && !bus.clear_err) || ovf_ev_s;
        unf_d     = (unf_q && !bus.clear_err) || unf_ev_s;

        if (bus.flush) begin
            wr_ptr_d     = wr_ptr_q;
            rd_ptr_d     = wr_ptr_q;
            ram_cnt_d    = '0;
            inflight_d   = 1'b0;
            os_mem_d     = '0;
            os_rd_d      = 1'b0;
            os_wr_d      = 1'b0;
            os_cnt_d     = 2'd0;
            level_d      = '0;
            ns_rd_data_s = '0;
        end else begin
            wr_ptr_d   = wr_ptr_q + ADDRWIDTH'(wr_acc_s);
            rd_ptr_d   = rd_ptr_q + ADDRWIDTH'(pre_s);
            ram_cnt_d  = ram_cnt_q + (ADDRWIDTH + 1)'(wr_acc_s) - (ADDRWIDTH + 1)'(pre_s);
            inflight_d = pre_s;
            os_mem_d   = os_mem_q;
            if (inflight_q) begin
                os_mem_d[os_wr_q] = ram_dout_s;
            end else begin
                os_mem_d = os_mem_q;
            end
            os_rd_d  = rd_n_s;
            os_wr_d  = os_wr_q ^ inflight_q;
            os_cnt_d = os_cnt_q + os_cnt_t'(inflight_q) - os_cnt_t'(rd_acc_s);
            level_d  = level_q + LW'(wr_acc_s) - LW'(rd_acc_s);
            // The head after this cycle's pop is either a held word or the landing RAM read.
            if (remain_s != 2'd0) begin
                ns_rd_data_s = os_mem_q[rd_n_s];
            end else if (inflight_q) begin
                ns_rd_data_s = ram_dout_s;
            end else begin
                ns_rd_data_s = '0;
            end
        end

        ns_ne_s   = (os_cnt_d != 2'd0);
        ns_full_s = (level_d >= FULL_L);
    end

    // State and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
            os_mem_q   <= '0;
            os_rd_q    <= 1'b0;
            os_wr_q    <= 1'b0;
            os_cnt_q   <= 2'd0;
            level_q    <= '0;
            rd_data_q  <= '0;
            ne_q       <= 1'b0;
            full_q     <= 1'b0;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= inflight_d;
            os_mem_q   <= os_mem_d;
            os_rd_q    <= os_rd_d;
            os_wr_q    <= os_wr_d;
            os_cnt_q   <= os_cnt_d;
            level_q    <= level_d;
            rd_data_q  <= ns_rd_data_s;
            ne_q       <= ns_ne_s;
            full_q     <= ns_full_s;
            af_q       <= (level_d >= bus.af_level);
            ae_q       <= (level_d <= bus.ae_level);
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    assign bus.ns_full      = ns_full_s;
    assign bus.full         = full_q;
    assign bus.almost_full  = af_q;
    assign bus.ovf          = ovf_q;
    assign bus.ns_rd_data   = ns_rd_data_s;
    assign bus.rd_data      = rd_data_q;
    assign bus.ns_ne        = ns_ne_s;
    assign bus.ne           = ne_q;
    assign bus.almost_empty = ae_q;
    assign bus.level        = level_q;
    assign bus.unf          = unf_q;

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// Directed bench for fifo_sync_fwft with ADDRWIDTH=3 (capacity 10), SLOP=2, 18-bit data.
// A vector table covers latency, underflow and simultaneous access; sequences cover the rest.
module tb_fifo_sync_fwft;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;

    fifo_sync_fwft_if #(.DATAWIDTH(18), .LW(5)) bus ();

    fifo_sync_fwft #(.DATAWIDTH(18), .ADDRWIDTH(3), .SLOP(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic        clr;
        logic [17:0] wd;
        logic        e_ns_ne;
        logic [17:0] e_ns_rd;
        logic [4:0]  e_lvl;
        logic        e_ne;
        logic [17:0] e_rd;
        logic        e_unf;
    } vec_t;

    vec_t        tbl [15];
    logic [17:0] q [$];
    logic [17:0] exp_w;
    int          written;
    int          cyc;
    bit          dwe;
    bit          dre;
    bit          ok;

    function automatic vec_t mk(logic we, logic re, logic clr, logic [17:0] wd,
                                logic ens, logic [17:0] enr, logic [4:0] lvl,
                                logic ene, logic [17:0] erd, logic eunf);
        vec_t v;
        v.we = we; v.re = re; v.clr = clr; v.wd = wd;
        v.e_ns_ne = ens; v.e_ns_rd = enr; v.e_lvl = lvl;
        v.e_ne = ene; v.e_rd = erd; v.e_unf = eunf;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ne(output bit okv);
        int n;
        n = 0;
        while (!bus.ne && n < 16) begin
            tick();
            n++;
        end
        okv = bus.ne;
        if (!okv) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_ne: ne still 0 after %0d cycles, want 1", n);
        end
    endtask

    task automatic write_word(input logic [17:0] d);
        bus.we      = 1'b1;
        bus.wr_data = d;
        tick();
        bus.we      = 1'b0;
    endtask

    task automatic read_expect(input string name, input logic [17:0] d);
        bit okv;
        wait_ne(okv);
        chk(name, 32'(bus.rd_data), 32'(d));
        bus.re = 1'b1;
        tick();
        bus.re = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.clear_err = 1'b0;
        bus.we        = 1'b0;
        bus.re        = 1'b0;
        bus.wr_data   = 18'd0;
        bus.af_level  = 5'd5;
        bus.ae_level  = 5'd2;

        //         we    re    clr   wd         ns_ne ns_rd      lvl   ne    rd         unf
        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 18'h002A5, 1'b0, 18'h0,     5'd1, 1'b0, 18'h0,     1'b0);
        tbl[1]  = mk(1'b0, 1'b0, 1'b0, 18'h0,     1'b0, 18'h0,     5'd1, 1'b0, 18'h0,     1'b0);
        tbl[2]  = mk(1'b0, 1'b0, 1'b0, 18'h0,     1'b1, 18'h002A5, 5'd1, 1'b1, 18'h002A5, 1'b0);
        tbl[3]  = mk(1'b0, 1'b1, 1'b0, 18'h0,     1'b0, 18'h0,     5'd0, 1'b0, 18'h0,     1'b0);
        tbl[4]  = mk(1'b0, 1'b1, 1'b0, 18'h0,     1'b0, 18'h0,     5'd0, 1'b0, 18'h0,     1'b1);
        tbl[5]  = mk(1'b0, 1'b0, 1'b1, 18'h0,     1'b0, 18'h0,     5'd0, 1'b0, 18'h0,     1'b0);
        tbl[6]  = mk(1'b0, 1'b1, 1'b1, 18'h0,     1'b0, 18'h0,     5'd0, 1'b0, 18'h0,     1'b1);
        tbl[7]  = mk(1'b0, 1'b0, 1'b1, 18'h0,     1'b0, 18'h0,     5'd0, 1'b0, 18'h0,     1'b0);
        tbl[8]  = mk(1'b1, 1'b0, 1'b0, 18'h00011, 1'b0, 18'h0,     5'd1, 1'b0, 18'h0,     1'b0);
        tbl[9]  = mk(1'b1, 1'b0, 1'b0, 18'h00022, 1'b0, 18'h0,     5'd2, 1'b0, 18'h0,     1'b0);
        tbl[10] = mk(1'b0, 1'b0, 1'b0, 18'h0,     1'b1, 18'h00011, 5'd2, 1'b1, 18'h00011, 1'b0);
        tbl[11] = mk(1'b1, 1'b1, 1'b0, 18'h00033, 1'b1, 18'h00022, 5'd2, 1'b1, 18'h00022, 1'b0);
        tbl[12] = mk(1'b0, 1'b1, 1'b0, 18'h0,     1'b0, 18'h0,     5'd1, 1'b0, 18'h0,     1'b0);
        tbl[13] = mk(1'b0, 1'b0, 1'b0, 18'h0,     1'b1, 18'h00033, 5'd1, 1'b1, 18'h00033, 1'b0);
        tbl[14] = mk(1'b0, 1'b1, 1'b0, 18'h0,     1'b0, 18'h0,     5'd0, 1'b0, 18'h0,     1'b0);

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_ne", 32'(bus.ne), 32'd0);
        chk("rst_ae", 32'(bus.almost_empty), 32'd1);
        chk("rst_af", 32'(bus.almost_full), 32'd0);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_unf", 32'(bus.unf), 32'd0);

        // Vector table: one record per cycle, comb outputs checked mid-cycle.
        for (int i = 0; i < 15; i++) begin
            bus.we        = tbl[i].we;
            bus.re        = tbl[i].re;
            bus.clear_err = tbl[i].clr;
            bus.wr_data   = tbl[i].wd;
            #1;
            chk($sformatf("v%0d_ns_ne", i), 32'(bus.ns_ne), 32'(tbl[i].e_ns_ne));
            if (tbl[i].e_ns_ne) chk($sformatf("v%0d_ns_rd", i), 32'(bus.ns_rd_data), 32'(tbl[i].e_ns_rd));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_level", i), 32'(bus.level), 32'(tbl[i].e_lvl));
            chk($sformatf("v%0d_ne", i), 32'(bus.ne), 32'(tbl[i].e_ne));
            if (tbl[i].e_ne) chk($sformatf("v%0d_rd", i), 32'(bus.rd_data), 32'(tbl[i].e_rd));
            chk($sformatf("v%0d_unf", i), 32'(bus.unf), 32'(tbl[i].e_unf));
            chk($sformatf("v%0d_ovf", i), 32'(bus.ovf), 32'd0);
        end
        bus.we = 1'b0; bus.re = 1'b0; bus.clear_err = 1'b0;

        // Fill past capacity: af at 5, full at 8, word 11 dropped.
        for (int k = 1; k <= 11; k++) begin
            write_word(18'(k));
            chk($sformatf("fill%0d_level", k), 32'(bus.level), 32'((k < 10) ? k : 10));
            chk($sformatf("fill%0d_af", k), 32'(bus.almost_full), 32'(k >= 5));
            chk($sformatf("fill%0d_full", k), 32'(bus.full), 32'(k >= 8));
            chk($sformatf("fill%0d_ae", k), 32'(bus.almost_empty), 32'(k <= 2));
            chk($sformatf("fill%0d_ovf", k), 32'(bus.ovf), 32'(k == 11));
        end
        for (int k = 1; k <= 10; k++) read_expect($sformatf("fill_rd%0d", k), 18'(k));
        chk("fill_end_level", 32'(bus.level), 32'd0);
        chk("fill_end_ovf", 32'(bus.ovf), 32'd1);
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        chk("clear_ovf", 32'(bus.ovf), 32'd0);

        // Streaming around level 5 against a queue model.
        written = 0;
        cyc     = 0;
        while ((written < 200 || q.size() != 0) && cyc < 4000) begin
            dwe = (written < 200) && (q.size() < 5 || (q.size() < 8 && $urandom_range(0, 1) == 1));
            dre = bus.ne && (written == 200 || (q.size() >= 5 && $urandom_range(0, 2) != 0)
                             || $urandom_range(0, 3) == 0);
            bus.we      = dwe;
            bus.re      = dre;
            bus.wr_data = 18'(written + 256);
            if (dre && q.size() != 0) begin
                exp_w = q.pop_front();
                chk("stream_data", 32'(bus.rd_data), 32'(exp_w));
            end
            if (dwe) begin
                q.push_back(18'(written + 256));
                written++;
            end
            tick();
            cyc++;
            chk("stream_level", 32'(bus.level), 32'(q.size()));
        end
        bus.we = 1'b0; bus.re = 1'b0;
        if (cyc >= 4000) begin
            n_vec++;
            n_err++;
            $display("FAIL stream_timeout: cycles %0d, want fewer than 4000", cyc);
        end
        chk("stream_ovf", 32'(bus.ovf), 32'd0);
        chk("stream_unf", 32'(bus.unf), 32'd0);

        // At capacity a simultaneous we&re reads but drops the write.
        for (int i = 0; i < 10; i++) write_word(18'(18'h500 + i));
        wait_ne(ok);
        chk("bnd_level", 32'(bus.level), 32'd10);
        chk("bnd_head", 32'(bus.rd_data), 32'h500);
        bus.we = 1'b1; bus.re = 1'b1; bus.wr_data = 18'h5FF;
        tick();
        bus.we = 1'b0; bus.re = 1'b0;
        chk("bnd_level_after", 32'(bus.level), 32'd9);
        chk("bnd_ovf", 32'(bus.ovf), 32'd1);
        for (int i = 1; i < 10; i++) read_expect($sformatf("bnd_rd%0d", i), 18'(18'h500 + i));
        tick(); tick();
        chk("bnd_drained_ne", 32'(bus.ne), 32'd0);
        chk("bnd_drained_level", 32'(bus.level), 32'd0);

        // Flush at level 6 with a write in the same cycle.
        for (int i = 0; i < 6; i++) write_word(18'(18'h600 + i));
        tick(); tick(); tick();
        chk("fl_pre_level", 32'(bus.level), 32'd6);
        bus.flush = 1'b1; bus.we = 1'b1; bus.wr_data = 18'h6FF;
        tick();
        bus.flush = 1'b0; bus.we = 1'b0;
        chk("fl_level", 32'(bus.level), 32'd0);
        chk("fl_ne", 32'(bus.ne), 32'd0);
        chk("fl_ae", 32'(bus.almost_empty), 32'd1);
        chk("fl_ovf_kept", 32'(bus.ovf), 32'd1);
        bus.we = 1'b1; bus.wr_data = 18'h01234;
        #1;
        chk("fl_c0_ns_ne", 32'(bus.ns_ne), 32'd0);
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        chk("fl_c1_level", 32'(bus.level), 32'd1);
        chk("fl_c1_ns_ne", 32'(bus.ns_ne), 32'd0);
        tick();
        chk("fl_c2_ns_ne", 32'(bus.ns_ne), 32'd1);
        chk("fl_c2_ns_rd", 32'(bus.ns_rd_data), 32'h01234);
        chk("fl_c2_ne", 32'(bus.ne), 32'd0);
        tick();
        chk("fl_c3_ne", 32'(bus.ne), 32'd1);
        chk("fl_c3_rd", 32'(bus.rd_data), 32'h01234);
        bus.re = 1'b1;
        tick();
        bus.re = 1'b0;
        tick(); tick(); tick();
        chk("fl_only_new_ne", 32'(bus.ne), 32'd0);
        chk("fl_only_new_level", 32'(bus.level), 32'd0);

        // Asynchronous reset mid-stream at level 6 with both error flags set.
        bus.re = 1'b1;
        tick();
        bus.re = 1'b0;
        chk("pre_rst_unf", 32'(bus.unf), 32'd1);
        for (int i = 0; i < 6; i++) write_word(18'(18'h700 + i));
        tick(); tick();
        chk("pre_rst_level", 32'(bus.level), 32'd6);
        #3;
        reset = 1'b1;
        #1;
        chk("mid_rst_level", 32'(bus.level), 32'd0);
        chk("mid_rst_ne", 32'(bus.ne), 32'd0);
        chk("mid_rst_ns_ne", 32'(bus.ns_ne), 32'd0);
        chk("mid_rst_ovf", 32'(bus.ovf), 32'd0);
        chk("mid_rst_unf", 32'(bus.unf), 32'd0);
        chk("mid_rst_ae", 32'(bus.almost_empty), 32'd1);
        chk("mid_rst_af", 32'(bus.almost_full), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
